// File: rtl/ooo_pkg.sv
// ooo_pkg
// Shared definitions for the out-of-order core completion path.
// Holds the physical-register and ROB tag widths, the completion packet
// struct that the ROB, the reservation/LS stations and the completion
// arbiter all pass around, and the grant encoding used by the arbiter.
// No ports.

package ooo_pkg;

  localparam int PR_W  = 6;
  localparam int ROB_W = 4;

  // One finished result as it travels to the completion bus.
  typedef struct packed {
    logic [PR_W-1:0]  p_rd;
    logic             RegDest;
    logic [ROB_W-1:0] rob_num;
    logic             changeFlow;
    logic [31:0]      jb_addr;
  } compl_pkt_t;

  // Which requester owned the bus on the most recent broadcast.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/complete_arbiter_if.sv
// complete_arbiter_if
// Bundles the ALU and MEM result handshakes and the completion broadcast
// bus of the arbiter.
//   alu_* / mem_*   : valid + result fields from each execute pipe, ready back
//   complete, *_compl : broadcast toward map table, stations and ROB
// Modports:
//   slave  - the arbiter (consumes results, drives ready and broadcast)
//   master - the environment (drives results, observes ready and broadcast)

interface complete_arbiter_if;
  import ooo_pkg::*;

  logic             alu_valid;
  logic [PR_W-1:0]  alu_p_rd;
  logic             alu_RegDest;
  logic [ROB_W-1:0] alu_rob_num;
  logic             alu_changeFlow;
  logic [31:0]      alu_jb_addr;
  logic             alu_ready;

  logic             mem_valid;
  logic [PR_W-1:0]  mem_p_rd;
  logic             mem_RegDest;
  logic [ROB_W-1:0] mem_rob_num;
  logic             mem_changeFlow;
  logic [31:0]      mem_jb_addr;
  logic             mem_ready;

  logic             complete;
  logic [PR_W-1:0]  p_rd_compl;
  logic             RegDest_compl;
  logic [ROB_W-1:0] rob_num_compl;
  logic             changeFlow_compl;
  logic [31:0]      jb_addr_compl;

  modport slave (
    input  alu_valid, alu_p_rd, alu_RegDest, alu_rob_num, alu_changeFlow, alu_jb_addr,
    output alu_ready,
    input  mem_valid, mem_p_rd, mem_RegDest, mem_rob_num, mem_changeFlow, mem_jb_addr,
    output mem_ready,
    output complete, p_rd_compl, RegDest_compl, rob_num_compl, changeFlow_compl, jb_addr_compl
  );

  modport master (
    output alu_valid, alu_p_rd, alu_RegDest, alu_rob_num, alu_changeFlow, alu_jb_addr,
    input  alu_ready,
    output mem_valid, mem_p_rd, mem_RegDest, mem_rob_num, mem_changeFlow, mem_jb_addr,
    input  mem_ready,
    input  complete, p_rd_compl, RegDest_compl, rob_num_compl, changeFlow_compl, jb_addr_compl
  );

endinterface

// File: rtl/compl_fifo.sv
// compl_fifo
// Small DEPTH-entry FIFO of completion packets, one per execute pipe.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   push_i     : write data_i this cycle (caller guarantees not full)
//   pop_i      : drop the head this cycle (caller guarantees not empty)
//   flush_i    : discard every entry; wins over push/pop
//   data_i     : packet to write
//   head_o     : oldest packet (meaningless while empty)
//   empty_o, full_o : occupancy flags, from registered state only

module compl_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  compl_pkt_t data_i,
  output compl_pkt_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  compl_pkt_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && !flush_i && push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/complete_arbiter.sv
// complete_arbiter
// Shares the single completion broadcast bus between the ALU and MEM
// execute pipes. Each pipe feeds a private compl_fifo; every cycle at most
// one FIFO head is broadcast, round-robin on ties. A ROB recover discards
// everything buffered.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   recover  : ROB flush, empties both FIFOs and suppresses the broadcast
//   bus      : complete_arbiter_if.slave (pipe handshakes + broadcast bus)
// Tag widths come from ooo_pkg so the packet matches the ROB and stations.

module complete_arbiter
  import ooo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               recover,
  complete_arbiter_if.slave  bus
);

  compl_pkt_t alu_pkt, mem_pkt, alu_head, mem_head, out_pkt;
  logic       alu_empty, alu_full, mem_empty, mem_full;
  logic       alu_push, mem_push, alu_pop, mem_pop;
  logic       grant_alu, complete;
  grant_e     last_grant_q, last_grant_d;

  assign alu_pkt = '{p_rd: bus.alu_p_rd, RegDest: bus.alu_RegDest, rob_num: bus.alu_rob_num,
                     changeFlow: bus.alu_changeFlow, jb_addr: bus.alu_jb_addr};
  assign mem_pkt = '{p_rd: bus.mem_p_rd, RegDest: bus.mem_RegDest, rob_num: bus.mem_rob_num,
                     changeFlow: bus.mem_changeFlow, jb_addr: bus.mem_jb_addr};

  // Ready is purely the registered full flag: no pass-through when full.
  assign bus.alu_ready = ~alu_full;
  assign bus.mem_ready = ~mem_full;

  assign alu_push = bus.alu_valid & ~alu_full & ~recover;
  assign mem_push = bus.mem_valid & ~mem_full & ~recover;

  // ALU wins if it is the only one waiting, or on a tie when MEM went last.
  assign grant_alu = ~alu_empty & (mem_empty | (last_grant_q == GRANT_MEM));
  assign complete  = (~alu_empty | ~mem_empty) & ~recover;
  assign alu_pop   = complete & grant_alu;
  assign mem_pop   = complete & ~grant_alu;

  assign last_grant_d = complete ? (grant_alu ? GRANT_ALU : GRANT_MEM) : last_grant_q;

  // Round-robin memory; only an actual broadcast moves it, recover holds it.
  always_ff @(posedge clk) begin
    if (!rst) last_grant_q <= GRANT_MEM;
    else      last_grant_q <= last_grant_d;
  end

  compl_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push_i(alu_push), .pop_i(alu_pop), .flush_i(recover),
    .data_i(alu_pkt), .head_o(alu_head), .empty_o(alu_empty), .full_o(alu_full)
  );

  compl_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .rst(rst), .push_i(mem_push), .pop_i(mem_pop), .flush_i(recover),
    .data_i(mem_pkt), .head_o(mem_head), .empty_o(mem_empty), .full_o(mem_full)
  );

  // Idle bus carries all zeros so consumers never see a stale tag.
  assign out_pkt = !complete ? '0 : (grant_alu ? alu_head : mem_head);

  assign bus.complete         = complete;
  assign bus.p_rd_compl       = out_pkt.p_rd;
  assign bus.RegDest_compl    = out_pkt.RegDest;
  assign bus.rob_num_compl    = out_pkt.rob_num;
  assign bus.changeFlow_compl = out_pkt.changeFlow;
  assign bus.jb_addr_compl    = out_pkt.jb_addr;

endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter
// Directed bench for complete_arbiter. Each table row is one clock cycle:
// the inputs driven during that cycle and the outputs expected during it
// (outputs reflect state from earlier edges plus this cycle's recover).
// A hand-written sequence covers reset asserted mid-operation.

module tb_complete_arbiter;
  import ooo_pkg::*;

  typedef struct {
    logic       aV;
    compl_pkt_t a;
    logic       mV;
    compl_pkt_t m;
    logic       rec;
    logic       eC;
    compl_pkt_t e;
    logic       eAr;
    logic       eMr;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic recover = 1'b0;
  int   errors = 0;
  int   checks = 0;
  row_t rows[$];

  complete_arbiter_if bus();

  complete_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .recover(recover), .bus(bus)
  );

  // 10 ns core clock.
  always #5 clk = ~clk;

  function automatic compl_pkt_t pk(int prd, bit rd, int rob, bit cf, logic [31:0] jb);
    compl_pkt_t p;
    p.p_rd       = PR_W'(prd);
    p.RegDest    = rd;
    p.rob_num    = ROB_W'(rob);
    p.changeFlow = cf;
    p.jb_addr    = jb;
    return p;
  endfunction

  function automatic row_t mk(logic aV, compl_pkt_t a, logic mV, compl_pkt_t m, logic rec,
                              logic eC, compl_pkt_t e, logic eAr, logic eMr);
    row_t r;
    r.aV = aV; r.a = a; r.mV = mV; r.m = m; r.rec = rec;
    r.eC = eC; r.e = e; r.eAr = eAr; r.eMr = eMr;
    return r;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle worth of inputs, a little after the rising edge.
  task automatic applyStimulus(logic aV, compl_pkt_t a, logic mV, compl_pkt_t m, logic rec);
    bus.alu_valid      = aV;
    bus.alu_p_rd       = a.p_rd;
    bus.alu_RegDest    = a.RegDest;
    bus.alu_rob_num    = a.rob_num;
    bus.alu_changeFlow = a.changeFlow;
    bus.alu_jb_addr    = a.jb_addr;
    bus.mem_valid      = mV;
    bus.mem_p_rd       = m.p_rd;
    bus.mem_RegDest    = m.RegDest;
    bus.mem_rob_num    = m.rob_num;
    bus.mem_changeFlow = m.changeFlow;
    bus.mem_jb_addr    = m.jb_addr;
    recover            = rec;
  endtask

  task automatic checkOutput(int idx, logic eC, compl_pkt_t e, logic eAr, logic eMr);
    check("complete",   idx, 32'(bus.complete),         32'(eC));
    check("p_rd",       idx, 32'(bus.p_rd_compl),       32'(e.p_rd));
    check("RegDest",    idx, 32'(bus.RegDest_compl),    32'(e.RegDest));
    check("rob_num",    idx, 32'(bus.rob_num_compl),    32'(e.rob_num));
    check("changeFlow", idx, 32'(bus.changeFlow_compl), 32'(e.changeFlow));
    check("jb_addr",    idx, bus.jb_addr_compl,         e.jb_addr);
    check("alu_ready",  idx, 32'(bus.alu_ready),        32'(eAr));
    check("mem_ready",  idx, 32'(bus.mem_ready),        32'(eMr));
  endtask

  initial begin
    compl_pkt_t z;
    compl_pkt_t a1, m1, t1, t2, t33, t34, ba1, ba2, bm1, bm2, bm3;
    compl_pkt_t r1, r2, r3, r4, r5, h1, h2, x, y, w, u, v;
    z = '0;

    // Single ALU push, then MEM redirect push.
    a1  = pk(8'h0A, 1, 3, 0, 32'h0);
    m1  = pk(5, 0, 4, 1, 32'h0000_0400);
    // Tie and alternation.
    t1  = pk(1, 1, 1, 0, 32'h0);
    t2  = pk(2, 1, 5, 0, 32'h0);
    t33 = pk(33, 1, 2, 0, 32'h0);
    t34 = pk(34, 1, 6, 0, 32'h0);
    // Backpressure on MEM.
    ba1 = pk(10, 1, 7, 0, 32'h0);
    ba2 = pk(11, 1, 9, 0, 32'h0);
    bm1 = pk(20, 1, 8, 0, 32'h0);
    bm2 = pk(21, 1, 10, 0, 32'h0);
    bm3 = pk(22, 1, 11, 1, 32'h0000_1234);
    // Recover.
    r1  = pk(40, 1, 12, 0, 32'h0);
    r2  = pk(41, 1, 13, 0, 32'h0);
    r3  = pk(42, 1, 14, 0, 32'h0);
    r4  = pk(43, 1, 15, 0, 32'h0);
    r5  = pk(44, 1, 0, 1, 32'hDEAD_0000);
    h1  = pk(50, 1, 1, 0, 32'h0);
    h2  = pk(51, 0, 2, 0, 32'h0);

    rows.push_back(mk(1, a1,  0, z,   0, 0, z,   1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, a1,  1, 1));
    rows.push_back(mk(0, z,   1, m1,  0, 0, z,   1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, m1,  1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));

    rows.push_back(mk(1, t1,  1, t33, 0, 0, z,   1, 1));
    rows.push_back(mk(1, t2,  1, t34, 0, 1, t1,  1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, t33, 1, 0));
    rows.push_back(mk(0, z,   0, z,   0, 1, t2,  1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, t34, 1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));

    rows.push_back(mk(1, ba1, 1, bm1, 0, 0, z,   1, 1));
    rows.push_back(mk(1, ba2, 1, bm2, 0, 1, ba1, 1, 1));
    rows.push_back(mk(0, z,   1, bm3, 0, 1, bm1, 1, 0));
    rows.push_back(mk(0, z,   1, bm3, 0, 1, ba2, 1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, bm2, 1, 0));
    rows.push_back(mk(0, z,   0, z,   0, 1, bm3, 1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));

    rows.push_back(mk(1, r1,  1, r2,  0, 0, z,   1, 1));
    rows.push_back(mk(1, r3,  1, r4,  0, 1, r1,  1, 1));
    rows.push_back(mk(1, r5,  0, z,   1, 0, z,   1, 0));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));
    // Last grant was ALU before recover and must survive it: MEM wins the tie.
    rows.push_back(mk(1, h1,  1, h2,  0, 0, z,   1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, h2,  1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 1, h1,  1, 1));
    rows.push_back(mk(0, z,   0, z,   0, 0, z,   1, 1));

    // Reset held low for two cycles.
    applyStimulus(0, z, 0, z, 0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkOutput(-1, 0, z, 1, 1);

    foreach (rows[i]) begin
      @(posedge clk);
      #1 applyStimulus(rows[i].aV, rows[i].a, rows[i].mV, rows[i].m, rows[i].rec);
      #1 checkOutput(i, rows[i].eC, rows[i].e, rows[i].eAr, rows[i].eMr);
    end

    // Reset mid-operation beats enqueue and clears last_grant back to MEM.
    x = pk(60, 1, 3, 0, 32'h0);
    y = pk(61, 1, 4, 0, 32'h0);
    w = pk(62, 1, 5, 1, 32'h0000_0800);
    u = pk(63, 1, 6, 0, 32'h0);
    v = pk(7, 1, 7, 0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1, x, 1, y, 0);
    @(posedge clk);
    #1 applyStimulus(1, w, 0, z, 0);
    rst = 1'b0;
    #1 checkOutput(100, 1, y, 1, 1);
    @(posedge clk);
    #1 applyStimulus(0, z, 0, z, 0);
    rst = 1'b1;
    #1 checkOutput(101, 0, z, 1, 1);
    @(posedge clk);
    #1 applyStimulus(1, u, 1, v, 0);
    @(posedge clk);
    #1 applyStimulus(0, z, 0, z, 0);
    #1 checkOutput(102, 1, u, 1, 1);
    @(posedge clk);
    #1 checkOutput(103, 1, v, 1, 1);
    @(posedge clk);
    #1 checkOutput(104, 0, z, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
